timer_apb_master: RTL and testbench
===================================

TIMER_APB_MASTER -- requirements
Module: timer_apb_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, APB address width.
REQ-002 SHALL have parameter TIMEOUT, default 16, ACCESS-phase cycles allowed before abort (legal range 2..255).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 cmd_valid  input  1  command request.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid & cmd_ready.
REQ-007 cmd_write  input  1  1 = write, 0 = read.
REQ-008 cmd_addr  input  ADDR_W  byte address.
REQ-009 cmd_wdata  input  32  write data.
REQ-010 cmd_strb  input  4  byte-lane write strobes.
REQ-011 psel, penable, pwrite  output  1 each  APB control.
REQ-012 paddr  output  ADDR_W; pwdata  output  32; pstrb  output  4.
REQ-013 prdata  input  32; pready  input  1; pslverr  input  1.
REQ-014 rsp_valid  output  1; rsp_ready  input  1  response handshake.
REQ-015 rsp_rdata  output  32; rsp_err  output  1; rsp_timeout  output  1.

Function
REQ-016 SHALL implement FSM states IDLE, SETUP, ACCESS, RESP; one transfer outstanding at a time.
REQ-017 cmd_ready SHALL be 1 only in IDLE.
REQ-018 Accept in IDLE at edge T with cmd_addr[1:0]==0: latch cmd fields, enter SETUP; cycle T+1 psel=1, penable=0.
REQ-019 Accept with cmd_addr[1:0]!=0: no bus transfer; enter RESP with rsp_err=1, rsp_timeout=0, rsp_rdata=0.
REQ-020 SETUP SHALL always last exactly one cycle, then ACCESS (psel=1, penable=1).
REQ-021 paddr, pwrite, pwdata, pstrb SHALL be stable from SETUP through final ACCESS cycle.
REQ-022 Reads: pstrb=0, pwdata=0; writes: pstrb=cmd_strb, pwdata=cmd_wdata.
REQ-023 ACCESS with pready=1: capture rsp_err=pslverr, rsp_rdata=prdata (reads) or 0 (writes), drop psel/penable next cycle, enter RESP.
REQ-024 ACCESS with pready=0: hold; wait counter increments; counter reaching TIMEOUT without pready SHALL abort: enter RESP, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
REQ-025 Wait counter SHALL clear on every SETUP entry; saturating width ceil(log2(TIMEOUT+1)).
REQ-026 pready and timeout on same cycle: pready wins (normal completion).
REQ-027 RESP: rsp_valid=1, rsp_* stable until rsp_valid & rsp_ready; then IDLE next cycle.
REQ-028 Minimum accept-to-accept spacing SHALL be 4 cycles (IDLE, SETUP, ACCESS, RESP) with zero wait states and rsp_ready=1.
REQ-029 psel SHALL never be 1 in IDLE or RESP; penable SHALL never be 1 without psel.
REQ-030 pslverr and prdata SHALL be ignored when pready=0.

Reset
REQ-031 rst=1 SHALL immediately force IDLE and all outputs 0 (cmd_ready goes 1 once rst deasserts), abandoning any in-flight transfer without response.
REQ-032 Latched command registers and wait counter SHALL reset to 0.

Structure
REQ-033 State encoding and timer register offsets (TCR 0x00, TDR0 0x04, TDR1 0x08, TCMP0 0x0C, TCMP1 0x10, TIER 0x14, TISR 0x18, THCSR 0x1C) SHALL live in shared package timer_pkg.
REQ-034 Single module; no sub-module required.

Verification
REQ-035 Write 0x0000_0101 to 0x000, strb 0x3, pready tied 1 -> SETUP T+1, ACCESS T+2, rsp_valid T+3 with rsp_err=0.
REQ-036 Read 0x00C, prdata=0xFFFF_FFFF, pready low 3 ACCESS cycles -> penable held 4 cycles, rsp_rdata=0xFFFF_FFFF, rsp_err=0.
REQ-037 Write TCR wdata[11:8]=0x9 with pslverr=1 on pready -> rsp_err=1, rsp_timeout=0.
REQ-038 pready held 0, TIMEOUT=16 -> after 16 ACCESS cycles psel drops, rsp_err=1, rsp_timeout=1.
REQ-039 cmd_addr=0x006 -> psel never asserts, rsp_err=1 next cycle.
REQ-040 rst asserted mid-ACCESS, rsp_ready=0 in RESP -> outputs 0 asynchronously; RESP data held until rsp_ready.

Source files
------------

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared FSM encoding and timer register map for the APB timer master
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [7:0] TCR_OFS   = 8'h00;
  localparam logic [7:0] TDR0_OFS  = 8'h04;
  localparam logic [7:0] TDR1_OFS  = 8'h08;
  localparam logic [7:0] TCMP0_OFS = 8'h0C;
  localparam logic [7:0] TCMP1_OFS = 8'h10;
  localparam logic [7:0] TIER_OFS  = 8'h14;
  localparam logic [7:0] TISR_OFS  = 8'h18;
  localparam logic [7:0] THCSR_OFS = 8'h1C;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/timer_apb_master.sv
// rtl/timer_apb_master.sv - single-outstanding command-to-APB bridge with ACCESS-phase timeout
module timer_apb_master
  import timer_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [31:0]       cmd_wdata,
  input  logic [3:0]        cmd_strb,
  output logic              psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [31:0]       pwdata,
  output logic [3:0]        pstrb,
  input  logic [31:0]       prdata,
  input  logic              pready,
  input  logic              pslverr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              rsp_timeout
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic              write_q;
  logic [31:0]       wdata_q;
  logic [3:0]        strb_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_inc;
  logic [31:0]       rdata_q;
  logic              err_q;
  logic              to_q;
  logic              aligned;
  logic              timeout_hit;

  assign aligned     = is_word_aligned(cmd_addr[1:0]);
  assign cnt_inc     = cnt_q + 1'b1;
  assign timeout_hit = (cnt_inc == CNT_W'(TIMEOUT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      addr_q  <= '0;
      write_q <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (aligned) begin
              // read data/strobes are zeroed here so the bus sees clean values for reads
              addr_q  <= cmd_addr;
              write_q <= cmd_write;
              wdata_q <= cmd_write ? cmd_wdata : 32'h0;
              strb_q  <= cmd_write ? cmd_strb : 4'h0;
              cnt_q   <= '0;
            end else begin
              rdata_q <= '0;
              err_q   <= 1'b1;
              to_q    <= 1'b0;
            end
          end
        end
        ST_ACCESS: begin
          if (pready) begin
            rdata_q <= write_q ? 32'h0 : prdata;
            err_q   <= pslverr;
            to_q    <= 1'b0;
          end else begin
            if (cnt_q != CNT_W'(TIMEOUT)) cnt_q <= cnt_inc;
            if (timeout_hit) begin
              rdata_q <= '0;
              err_q   <= 1'b1;
              to_q    <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt   = state;
    cmd_ready   = 1'b0;
    psel        = 1'b0;
    penable     = 1'b0;
    rsp_valid   = 1'b0;
    case (state)
      ST_IDLE: begin
        cmd_ready = ~rst;
        if (cmd_valid) state_nxt = aligned ? ST_SETUP : ST_RESP;
      end
      ST_SETUP: begin
        psel      = 1'b1;
        state_nxt = ST_ACCESS;
      end
      ST_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
        // a slave completing on the timeout cycle still counts as a normal completion
        if (pready || timeout_hit) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign pwrite      = write_q;
  assign paddr       = addr_q;
  assign pwdata      = wdata_q;
  assign pstrb       = strb_q;
  assign rsp_rdata   = rdata_q;
  assign rsp_err     = err_q;
  assign rsp_timeout = to_q;

endmodule

// File: tb/tb_timer_apb_master.sv
// tb/tb_timer_apb_master.sv - self-checking bench for timer_apb_master
module tb_timer_apb_master;

  localparam int ADDR_W  = 12;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_write = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [31:0]       cmd_wdata = '0;
  logic [3:0]        cmd_strb = '0;
  logic              psel, penable, pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [31:0]       pwdata;
  logic [3:0]        pstrb;
  logic [31:0]       prdata = '0;
  logic              pready = 1'b0;
  logic              pslverr = 1'b0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b0;
  logic [31:0]       rsp_rdata;
  logic              rsp_err, rsp_timeout;

  always #5 clk = ~clk;

  timer_apb_master #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .pstrb(pstrb), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // transaction-level model: cycle k counts from the accept cycle (k=0)
  bit                active = 1'b0;
  int                k;
  bit                m_aligned, m_write, m_err, m_to;
  logic [ADDR_W-1:0] m_addr;
  logic [31:0]       m_wdata, m_rdata;
  logic [3:0]        m_strb;
  int                n_acc, r_start, m_d;
  int                pen_cycles, psel_cycles, rv_first_k;
  logic [31:0]       rv_rdata;
  logic              rv_err, rv_to;
  bit                e_psel, e_pen, e_rv, e_cr;

  always @(negedge clk) begin
    if (active) begin
      e_psel = m_aligned && k >= 1 && k < 2 + n_acc;
      e_pen  = m_aligned && k >= 2 && k < 2 + n_acc;
      e_rv   = k >= r_start && k <= r_start + m_d;
      e_cr   = (k == 0) || (k > r_start + m_d);
      chk("psel", 32'(psel), 32'(e_psel));
      chk("penable", 32'(penable), 32'(e_pen));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rv));
      chk("cmd_ready", 32'(cmd_ready), 32'(e_cr));
      if (e_psel) begin
        chk("paddr", 32'(paddr), 32'(m_addr));
        chk("pwrite", 32'(pwrite), 32'(m_write));
        chk("pwdata", pwdata, m_write ? m_wdata : 32'h0);
        chk("pstrb", 32'(pstrb), m_write ? 32'(m_strb) : 32'h0);
      end
      if (e_rv) begin
        chk("rsp_rdata", rsp_rdata, m_rdata);
        chk("rsp_err", 32'(rsp_err), 32'(m_err));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(m_to));
      end
      if (penable) pen_cycles++;
      if (psel) psel_cycles++;
      if (rsp_valid && rv_first_k < 0) begin
        rv_first_k = k;
        rv_rdata   = rsp_rdata;
        rv_err     = rsp_err;
        rv_to      = rsp_timeout;
      end
    end
  end

  task automatic run(input bit wr, input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                     input logic [3:0] strb, input int waits, input logic [31:0] rdata,
                     input bit slverr, input int d);
    bit to;
    m_aligned = (addr[1:0] == 2'b00);
    m_write   = wr;
    m_addr    = addr;
    m_wdata   = wdata;
    m_strb    = strb;
    m_d       = d;
    to        = m_aligned && waits >= TIMEOUT;
    n_acc     = !m_aligned ? 0 : (to ? TIMEOUT : waits + 1);
    r_start   = m_aligned ? 2 + n_acc : 1;
    m_to      = to;
    m_err     = !m_aligned || to || slverr;
    m_rdata   = (m_aligned && !to && !wr) ? rdata : 32'h0;
    pen_cycles  = 0;
    psel_cycles = 0;
    rv_first_k  = -1;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    cmd_strb  = strb;
    pready    = 1'b0;
    pslverr   = 1'b1;
    prdata    = 32'hDEAD_BEEF;
    rsp_ready = 1'b0;
    k         = 0;
    active    = 1'b1;
    while (k < r_start + d + 1) begin
      @(posedge clk);
      #1;
      k++;
      cmd_valid = 1'b0;
      cmd_addr  = '1;
      cmd_wdata = 32'h5A5A_5A5A;
      cmd_strb  = 4'hF;
      pready    = m_aligned && !to && (k == 2 + waits);
      pslverr   = pready ? slverr : 1'b1;
      prdata    = pready ? rdata : 32'hDEAD_BEEF;
      rsp_ready = (k >= r_start + d);
    end
  endtask

  initial begin
    #2;
    chk("reset_ctrl", 32'({psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, cmd_ready}), 32'h0);
    chk("reset_paddr", 32'(paddr), 32'h0);
    chk("reset_pwdata", pwdata, 32'h0);
    chk("reset_rdata", rsp_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", 32'(cmd_ready), 32'h1);

    run(1'b1, 12'h000, 32'h0000_0101, 4'h3, 0, 32'h1234_5678, 1'b0, 0);
    chk("w0_psel_cycles", 32'(psel_cycles), 32'd2);
    chk("w0_pen_cycles", 32'(pen_cycles), 32'd1);
    chk("w0_rsp_cycle", 32'(rv_first_k), 32'd3);
    chk("w0_rsp_err", 32'(rv_err), 32'h0);
    chk("w0_rsp_rdata", rv_rdata, 32'h0);

    run(1'b0, 12'h00C, 32'h0, 4'h0, 3, 32'hFFFF_FFFF, 1'b0, 3);
    chk("r_wait_pen_cycles", 32'(pen_cycles), 32'd4);
    chk("r_wait_rdata", rv_rdata, 32'hFFFF_FFFF);
    chk("r_wait_err", 32'(rv_err), 32'h0);

    run(1'b1, 12'h000, 32'h0000_0900, 4'hF, 1, 32'h0BAD_0BAD, 1'b1, 0);
    chk("slverr_err", 32'(rv_err), 32'h1);
    chk("slverr_timeout", 32'(rv_to), 32'h0);

    run(1'b0, 12'h004, 32'h0, 4'h0, 20, 32'h7777_7777, 1'b0, 1);
    chk("to_pen_cycles", 32'(pen_cycles), 32'd16);
    chk("to_rsp_cycle", 32'(rv_first_k), 32'd18);
    chk("to_err", 32'(rv_err), 32'h1);
    chk("to_timeout", 32'(rv_to), 32'h1);

    run(1'b0, 12'h006, 32'h0, 4'h0, 0, 32'h1111_1111, 1'b0, 0);
    chk("mis_psel_cycles", 32'(psel_cycles), 32'd0);
    chk("mis_rsp_cycle", 32'(rv_first_k), 32'd1);
    chk("mis_err", 32'(rv_err), 32'h1);

    run(1'b0, 12'h008, 32'h0, 4'h0, 15, 32'hCAFE_F00D, 1'b0, 0);
    chk("edge_pen_cycles", 32'(pen_cycles), 32'd16);
    chk("edge_timeout", 32'(rv_to), 32'h0);
    chk("edge_rdata", rv_rdata, 32'hCAFE_F00D);

    run(1'b1, 12'h01C, 32'h0000_00FF, 4'h1, 2, 32'h2222_2222, 1'b0, 2);
    chk("w1c_rdata", rv_rdata, 32'h0);

    // reset in the middle of a stalled write
    active    = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr  = 12'h014;
    cmd_wdata = 32'hA5A5_A5A5;
    cmd_strb  = 4'hF;
    pready    = 1'b0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_access", 32'({psel, penable, pwrite}), 32'h7);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_ctrl", 32'({psel, penable, pwrite, rsp_valid, rsp_err, rsp_timeout, cmd_ready}), 32'h0);
    chk("async_rst_paddr", 32'(paddr), 32'h0);
    chk("async_rst_pwdata", pwdata, 32'h0);
    chk("async_rst_pstrb", 32'(pstrb), 32'h0);
    @(posedge clk);
    #1;
    chk("held_rst_psel", 32'(psel), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_ready", 32'(cmd_ready), 32'h1);
    chk("post_rst_no_rsp", 32'(rsp_valid), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
